// File: rtl/neopixel_receiver.sv
// neopixel_receiver: decodes a NeoPixel serial line into addressed byte writes with frame tracking
// Ports: i_clk clock; i_rst_n synchronous active-low reset; i_din asynchronous data line;
//   o_wr_en/o_wr_addr/o_wr_data byte write strobe; o_frame_done/o_frame_bytes frame end and byte count;
//   o_err protocol error pulse; o_busy frame in progress
module neopixel_receiver #(
  parameter int LEDS   = 200,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_din,
  output logic                           o_wr_en,
  output logic [$clog2(LEDS*3)-1:0]      o_wr_addr,
  output logic [7:0]                     o_wr_data,
  output logic                           o_frame_done,
  output logic [$clog2(LEDS*3+1)-1:0]    o_frame_bytes,
  output logic                           o_err,
  output logic                           o_busy
);
  localparam int NBYTES         = LEDS * 3;
  localparam int AW             = $clog2(NBYTES);
  localparam int FW             = $clog2(NBYTES + 1);
  localparam int TPU            = CLK_HZ / 1_000_000;
  localparam int MIN_HI_TCK     = TPU / 10;
  localparam int BIT_THRESH_TCK = TPU * 52 / 100;
  localparam int MAX_HI_TCK     = TPU * 6 / 5;
  localparam int RST_TCK        = TPU * 50;
  localparam int CW             = $clog2(RST_TCK + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_HI_TCK);
  localparam logic [CW-1:0] TH_C  = CW'(BIT_THRESH_TCK);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HI_TCK);
  localparam logic [CW-1:0] RST_C = CW'(RST_TCK);
  localparam logic [FW-1:0] NB_C  = FW'(NBYTES);
  typedef enum logic [1:0] {SYNC, IDLE, HI, LO} state_t;
  state_t          state_q, state_d;
  logic            din_m_q, din_s_q, din_p_q;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2:0]      bits_q, bits_d;
  logic [7:0]      shift_q, shift_d;
  logic [FW-1:0]   nbytes_q, nbytes_d;
  logic            ovf_q, ovf_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            done_q, done_d;
  logic [FW-1:0]   fb_q, fb_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    nbytes_d  = nbytes_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    fb_d      = fb_q;
    err_d     = 1'b0;
    case (state_q)
      SYNC: begin
        cnt_d   = din_s_q ? '0 : cnt_inc;
        state_d = (!din_s_q && cnt_inc == RST_C) ? IDLE : SYNC;
      end
      IDLE: if (din_s_q && !din_p_q) begin
        state_d  = HI;
        cnt_d    = CW'(1);
        nbytes_d = '0;
        bits_d   = '0;
        ovf_d    = 1'b0;
      end
      HI: if (din_s_q) begin
        cnt_d = cnt_inc;
        if (cnt_inc > MAX_C) begin
          err_d   = 1'b1;
          state_d = SYNC;
          cnt_d   = '0;
        end
      end else if (cnt_q < MIN_C) begin
        // the falling cycle itself is the first low sample of the resync gap
        err_d   = 1'b1;
        state_d = SYNC;
        cnt_d   = CW'(1);
      end else begin
        shift_d = {shift_q[6:0], cnt_q >= TH_C};
        bits_d  = bits_q + 3'd1;
        state_d = LO;
        cnt_d   = CW'(1);
        if (bits_q == 3'd7) begin
          if (nbytes_q == NB_C) ovf_d = 1'b1;
          else begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(nbytes_q);
            wr_data_d = shift_d;
            nbytes_d  = nbytes_q + 1'b1;
          end
        end
      end
      LO: if (din_s_q) begin
        state_d = HI;
        cnt_d   = CW'(1);
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == RST_C) begin
          done_d  = 1'b1;
          fb_d    = nbytes_q;
          err_d   = (bits_q != 3'd0) || ovf_q;
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= SYNC;
      din_m_q   <= 1'b0;
      din_s_q   <= 1'b0;
      din_p_q   <= 1'b0;
      cnt_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      nbytes_q  <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      fb_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_m_q   <= i_din;
      din_s_q   <= din_m_q;
      din_p_q   <= din_s_q;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      nbytes_q  <= nbytes_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      fb_q      <= fb_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_frame_done  = done_q;
  assign o_frame_bytes = fb_q;
  assign o_err         = err_q;
  assign o_busy        = (state_q == HI) || (state_q == LO);
endmodule

// File: tb/tb_neopixel_receiver.sv
// tb_neopixel_receiver: self-checking bench for neopixel_receiver (frame size scaled via LEDS)
module tb_neopixel_receiver;
  localparam int LEDS = 20;
  localparam int NB   = LEDS * 3;
  localparam int AW   = $clog2(NB);
  localparam int FW   = $clog2(NB + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic wr_en, frame_done, err, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [FW-1:0] frame_bytes;

  neopixel_receiver #(.LEDS(LEDS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_done(frame_done), .o_frame_bytes(frame_bytes),
    .o_err(err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int nbytes;
    int xbits;
    int mode;
    bit ramp;
    int ew;
    int efb;
    int eerr;
  } vec_t;
  vec_t tbl[5];

  int checks = 0, errors = 0;
  int cyc = 0, last_fall = 0;
  int wa[$], wd[$], wc[$];
  int n_done = 0, n_err = 0, last_fb = 0, done_err = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      wc.push_back(cyc);
    end
    if (frame_done) begin
      n_done++;
      last_fb = int'(frame_bytes);
      done_err = int'(err);
    end
    if (err) n_err++;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    last_fall = cyc;
    hold(1'b0, l);
  endtask

  // mode 0: nominal timing, mode 1: shortest legal timing, mode 2: random legal timing
  task automatic send_bits(input logic [7:0] b, input int nb, input int mode);
    int th, tl;
    for (int i = 7; i > 7 - nb; i--) begin
      if (mode == 0) begin
        th = b[i] ? 35 : 18;
        tl = b[i] ? 30 : 40;
      end else if (mode == 1) begin
        th = b[i] ? 26 : 5;
        tl = 1;
      end else begin
        th = b[i] ? int'($urandom_range(60, 26)) : int'($urandom_range(25, 5));
        tl = int'($urandom_range(20, 1));
      end
      pulse(th, tl);
    end
  endtask

  task automatic frame(input string nm, input int nbytes, input int xbits, input int mode,
                       input bit ramp, input int ew, input int efb, input int eerr);
    int bw, bd, be, nw;
    logic [7:0] q[$];
    logic [7:0] b;
    bw = wa.size();
    bd = n_done;
    be = n_err;
    for (int k = 0; k < nbytes; k++) begin
      b = ramp ? 8'(k) : 8'($urandom);
      q.push_back(b);
      send_bits(b, 8, mode);
    end
    if (xbits != 0) begin
      b = 8'($urandom);
      send_bits(b, xbits, mode);
    end
    hold(1'b0, 2600);
    nw = wa.size() - bw;
    chk({nm, "_writes"}, nw, ew);
    chk({nm, "_done"}, n_done - bd, 1);
    chk({nm, "_bytes"}, last_fb, efb);
    chk({nm, "_err"}, n_err - be, eerr);
    chk({nm, "_done_err"}, done_err, eerr);
    for (int k = 0; k < nw && k < ew; k++) begin
      chk($sformatf("%s_addr%0d", nm, k), wa[bw+k], k);
      chk($sformatf("%s_data%0d", nm, k), wd[bw+k], int'(q[k]));
    end
  endtask

  task automatic bad_pulse(input string nm, input int h);
    int bw, bd, be;
    bw = wa.size();
    bd = n_done;
    be = n_err;
    pulse(h, 2500);
    chk({nm, "_writes"}, wa.size() - bw, 0);
    chk({nm, "_done"}, n_done - bd, 0);
    chk({nm, "_err"}, n_err - be, 1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_wr_en"}, int'(wr_en), 0);
    chk({nm, "_wr_addr"}, int'(wr_addr), 0);
    chk({nm, "_wr_data"}, int'(wr_data), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
    chk({nm, "_frame_bytes"}, int'(frame_bytes), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int bw, bd, be, nw, f0, nb, xb;
    logic [7:0] px[3];
    px[0] = 8'hFF;
    px[1] = 8'h00;
    px[2] = 8'hA5;
    tbl[0] = '{"one_byte", 1, 0, 0, 1'b0, 1, 1, 0};
    tbl[1] = '{"bits12", 1, 4, 0, 1'b0, 1, 1, 1};
    tbl[2] = '{"full", NB, 0, 1, 1'b1, NB, NB, 0};
    tbl[3] = '{"overflow", NB + 1, 0, 1, 1'b1, NB, NB, 1};
    tbl[4] = '{"bits7", 0, 7, 1, 1'b0, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    hold(1'b0, 2500);

    bw = wa.size();
    bd = n_done;
    be = n_err;
    send_bits(8'hFF, 8, 0);
    f0 = last_fall;
    chk("pixel_busy", int'(busy), 1);
    send_bits(8'h00, 8, 0);
    send_bits(8'hA5, 8, 0);
    hold(1'b0, 2500);
    nw = wa.size() - bw;
    chk("pixel_writes", nw, 3);
    for (int k = 0; k < nw && k < 3; k++) begin
      chk($sformatf("pixel_addr%0d", k), wa[bw+k], k);
      chk($sformatf("pixel_data%0d", k), wd[bw+k], int'(px[k]));
    end
    if (nw > 0) chk("pixel_latency", wc[bw] - f0, 3);
    chk("pixel_done", n_done - bd, 1);
    chk("pixel_bytes", last_fb, 3);
    chk("pixel_err", n_err - be, 0);
    chk("pixel_idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++)
      frame(tbl[i].nm, tbl[i].nbytes, tbl[i].xbits, tbl[i].mode, tbl[i].ramp,
            tbl[i].ew, tbl[i].efb, tbl[i].eerr);

    bad_pulse("long70", 70);
    bad_pulse("glitch3", 3);
    bad_pulse("long61", 61);
    bad_pulse("short4", 4);
    bw = wa.size();
    bd = n_done;
    be = n_err;
    send_bits(8'h81, 8, 0);
    send_bits(8'hFF, 2, 0);
    pulse(70, 2500);
    chk("midframe_writes", wa.size() - bw, 1);
    chk("midframe_done", n_done - bd, 0);
    chk("midframe_err", n_err - be, 1);
    frame("after_err", 1, 0, 0, 1'b0, 1, 1, 0);

    for (int r = 0; r < 3; r++) begin
      nb = int'($urandom_range(6, 1));
      xb = (r == 1 || $urandom_range(2, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      frame($sformatf("rnd%0d", r), nb, xb, 2, 1'b0,
            (nb > NB) ? NB : nb, (nb > NB) ? NB : nb, (xb != 0 || nb > NB) ? 1 : 0);
    end

    bw = wa.size();
    send_bits(8'h3C, 8, 0);
    send_bits(8'hC3, 3, 0);
    chk("rst_pre_writes", wa.size() - bw, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    bw = wa.size();
    bd = n_done;
    be = n_err;
    send_bits(8'h5A, 5, 0);
    send_bits(8'h77, 8, 0);
    hold(1'b0, 2600);
    chk("rst_ignored_writes", wa.size() - bw, 0);
    chk("rst_ignored_done", n_done - bd, 0);
    chk("rst_ignored_err", n_err - be, 0);
    frame("post_rst", 2, 0, 2, 1'b0, 2, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
